// File: rtl/adc_sampler.sv
// adc_sampler: round counter, MCP3002 channel-0 SPI sampler and post-reset DC bias calibration.
// Optional macro ADC_SAMPLER_RECAL_EN adds a recal input that reruns the calibration average.
module adc_sampler #(
    parameter int ROUND_LEN = 1000,
    parameter int SCLK_DIV  = 10,
    parameter int CAL_LOG2  = 6
) (
    input  logic       clk,
    input  logic       reset,
`ifdef ADC_SAMPLER_RECAL_EN
    input  logic       recal,
`endif
    input  logic       adcMiso,
    output logic       adcSclk,
    output logic       adcCs,
    output logic       adcMosi,
    output logic [9:0] counter,
    output logic [9:0] sampleVoltage,
    output logic [9:0] offset,
    output logic       calDone,
    output logic       sampleValid
);

    localparam int DW    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int ACC_W = 10 + CAL_LOG2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    if (ROUND_LEN < 34 * SCLK_DIV + 4 || ROUND_LEN > 1024) begin : g_bad_cfg
        $error("adc_sampler: ROUND_LEN must fit one conversion and the 10-bit counter");
    end

    logic [9:0]          counter_q, counter_d;
    logic [1:0]          state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [3:0]          per_q, per_d;
    logic                half_q, half_d;
    logic                sclk_q, sclk_d;
    logic                cs_q, cs_d;
    logic                mosi_q, mosi_d;
    logic [9:0]          shreg_q, shreg_d;
    logic [9:0]          sample_q, sample_d;
    logic                valid_q, valid_d;
    logic [9:0]          offset_q, offset_d;
    logic                cal_done_q, cal_done_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CAL_LOG2-1:0] cnt_q, cnt_d;

    logic             latch;
    logic             div_end;
    logic             clr;
    logic [ACC_W-1:0] sum;

`ifdef ADC_SAMPLER_RECAL_EN
    assign clr = recal;
`else
    assign clr = 1'b0;
`endif

    // Command word, period index 0..15: start, single-ended, ch0, MSB-first, then zeros.
    function automatic logic mosi_bit(input logic [3:0] idx);
        return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd3);
    endfunction

    // Registered one cycle early so the new sample and its pulse are seen at counter ROUND_LEN-1.
    assign latch   = (counter_q == 10'(ROUND_LEN - 2));
    assign div_end = (div_q == DW'(SCLK_DIV - 1));
    assign sum     = acc_q + ACC_W'(shreg_q);

    always_comb begin
        counter_d = (counter_q == 10'(ROUND_LEN - 1)) ? 10'd0 : counter_q + 10'd1;
        state_d   = state_q;
        div_d     = div_q;
        per_d     = per_q;
        half_d    = half_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        shreg_d   = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (counter_q == 10'd1) begin
                    cs_d    = 1'b0;
                    mosi_d  = mosi_bit(4'd0);
                    div_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    per_d   = 4'd0;
                    half_d  = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_SHIFT: begin
                if (!div_end) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d = '0;
                    if (!half_q) begin
                        sclk_d = 1'b1;
                        half_d = 1'b1;
                        // Periods 7..16 carry the 10 result bits, MSB first.
                        if (per_q >= 4'd6) shreg_d = {shreg_q[8:0], adcMiso};
                    end else begin
                        sclk_d = 1'b0;
                        half_d = 1'b0;
                        if (per_q == 4'd15) begin
                            mosi_d  = 1'b0;
                            state_d = S_HOLD;
                        end else begin
                            per_d  = per_q + 4'd1;
                            mosi_d = mosi_bit(per_q + 4'd1);
                        end
                    end
                end
            end
            default: begin
                if (div_end) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
        endcase
    end

    always_comb begin
        sample_d   = sample_q;
        valid_d    = latch;
        offset_d   = offset_q;
        cal_done_d = cal_done_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        if (latch) sample_d = shreg_q;
        // A recal on a latch cycle wins: the sample is dropped from the new average.
        if (clr) begin
            acc_d      = '0;
            cnt_d      = '0;
            cal_done_d = 1'b0;
        end else if (latch && !cal_done_q) begin
            if (&cnt_q) begin
                offset_d   = sum[CAL_LOG2 +: 10];
                cal_done_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CAL_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_q  <= 10'd0;
            state_q    <= S_IDLE;
            div_q      <= '0;
            per_q      <= 4'd0;
            half_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            shreg_q    <= 10'd0;
            sample_q   <= 10'h200;
            valid_q    <= 1'b0;
            offset_q   <= 10'h200;
            cal_done_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            counter_q  <= counter_d;
            state_q    <= state_d;
            div_q      <= div_d;
            per_q      <= per_d;
            half_q     <= half_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            shreg_q    <= shreg_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            offset_q   <= offset_d;
            cal_done_q <= cal_done_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign counter       = counter_q;
    assign adcSclk       = sclk_q;
    assign adcCs         = cs_q;
    assign adcMosi       = mosi_q;
    assign sampleVoltage = sample_q;
    assign sampleValid   = valid_q;
    assign offset        = offset_q;
    assign calDone       = cal_done_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler: reset, SPI framing, sample latch, calibration, reset mid-conversion.
// A second instance with CAL_LOG2=2 shares the SPI bus to check the averaging path with a non-midscale result.
module tb_adc_sampler;

`ifdef ADC_SAMPLER_RECAL_EN
    localparam int RL = 500;
`else
    localparam int RL = 1000;
`endif
    localparam int SD = 10;
    localparam logic [9:0] LAST = 10'(RL - 1);
    localparam logic [9:0] PEN  = 10'(RL - 2);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       recal = 1'b0;
    logic [9:0] adc_val = 10'd0;
    logic       adcMiso, adcSclk, adcCs, adcMosi, calDone, sampleValid;
    logic [9:0] counter, sampleVoltage, offset;
    logic       sclk2, cs2, mosi2, calDone2, valid2;
    logic [9:0] counter2, sample2, offset2;

    int n_cmp = 0;
    int n_err = 0;
    int stray = 0;

    always #5 clk = ~clk;

    adc_sampler #(.ROUND_LEN(RL), .SCLK_DIV(SD), .CAL_LOG2(6)) u_dut (
        .clk(clk), .reset(reset),
`ifdef ADC_SAMPLER_RECAL_EN
        .recal(recal),
`endif
        .adcMiso(adcMiso), .adcSclk(adcSclk), .adcCs(adcCs), .adcMosi(adcMosi),
        .counter(counter), .sampleVoltage(sampleVoltage), .offset(offset),
        .calDone(calDone), .sampleValid(sampleValid)
    );

    adc_sampler #(.ROUND_LEN(RL), .SCLK_DIV(SD), .CAL_LOG2(2)) u_dut2 (
        .clk(clk), .reset(reset),
`ifdef ADC_SAMPLER_RECAL_EN
        .recal(recal),
`endif
        .adcMiso(adcMiso), .adcSclk(sclk2), .adcCs(cs2), .adcMosi(mosi2),
        .counter(counter2), .sampleVoltage(sample2), .offset(offset2),
        .calDone(calDone2), .sampleValid(valid2)
    );

    // ADC model: prd is the current SCLK period (1..16); data bits go out in periods 7..16.
    int          prd = 1;
    int          nrise = 0;
    logic [15:0] mosi_seen = 16'd0;
    logic        cs_l = 1'b1;
    logic        sclk_l = 1'b0;

    function automatic logic miso_of(input int p, input logic [9:0] v);
        if (p < 7 || p > 16) return 1'b0;
        return v[4'(16 - p)];
    endfunction

    assign adcMiso = miso_of(prd, adc_val);

    always @(adcCs or adcSclk) begin
        if (adcCs !== cs_l) begin
            prd = 1;
            if (!adcCs) nrise = 0;
            cs_l = adcCs;
        end else if (!adcCs && adcSclk !== sclk_l) begin
            if (adcSclk) begin
                if (prd <= 16) mosi_seen[4'(prd - 1)] = adcMosi;
                nrise++;
            end else begin
                prd++;
            end
        end
        sclk_l = adcSclk;
    end

    always @(negedge clk)
        if (reset && sampleValid && counter != LAST) stray++;

    task automatic wait_cnt(input logic [9:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (counter == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (counter !== 10'd0) begin n_err++; $display("FAIL rst_counter: got %h want 000", counter); end
        n_cmp++; if (adcCs !== 1'b1) begin n_err++; $display("FAIL rst_cs: got %b want 1", adcCs); end
        n_cmp++; if (adcSclk !== 1'b0) begin n_err++; $display("FAIL rst_sclk: got %b want 0", adcSclk); end
        n_cmp++; if (sampleVoltage !== 10'h200) begin n_err++; $display("FAIL rst_sample: got %h want 200", sampleVoltage); end
        n_cmp++; if (offset !== 10'h200) begin n_err++; $display("FAIL rst_offset: got %h want 200", offset); end
        n_cmp++; if (calDone !== 1'b0) begin n_err++; $display("FAIL rst_caldone: got %b want 0", calDone); end
        n_cmp++; if (sampleValid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", sampleValid); end
    endtask

    task automatic test_conversion;
        int n;
        bit ok;
        logic [9:0] c;
        adc_val = 10'h2A5;
        reset = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2 * RL; i++) begin
            @(negedge clk);
            if (!adcCs) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cs_fall: adcCs got 1 want 0 within budget"); end
        c = counter;
        n_cmp++; if (c !== 10'd2) begin n_err++; $display("FAIL cs_fall_counter: got %0d want 2", c); end
        n = 0;
        while (!adcCs && n < 2 * RL) begin @(negedge clk); n++; end
        n_cmp++; if (n != 34 * SD) begin n_err++; $display("FAIL cs_low_len: got %0d want %0d", n, 34 * SD); end
        n_cmp++; if (mosi_seen[3:0] !== 4'b1011) begin n_err++; $display("FAIL mosi_cmd: got %b want 1011 (rise4..1)", mosi_seen[3:0]); end
        n_cmp++; if (nrise != 16) begin n_err++; $display("FAIL sclk_rises: got %0d want 16", nrise); end
        wait_cnt(LAST, 2 * RL, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL latch_wait: counter got %0d want %0d", counter, LAST); end
        n_cmp++; if (sampleVoltage !== 10'h2A5) begin n_err++; $display("FAIL latch_sample: got %h want 2a5", sampleVoltage); end
        n_cmp++; if (sampleValid !== 1'b1) begin n_err++; $display("FAIL latch_valid: got %b want 1", sampleValid); end
        n_cmp++; if (calDone !== 1'b0) begin n_err++; $display("FAIL latch_caldone: got %b want 0", calDone); end
        @(negedge clk);
        n_cmp++; if (sampleValid !== 1'b0) begin n_err++; $display("FAIL valid_width: got %b want 0", sampleValid); end
        n_cmp++; if (counter !== 10'd0) begin n_err++; $display("FAIL wrap: got %0d want 0", counter); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        adc_val = 10'h1F0;
        wait_cnt(10'd100, 2 * RL, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_wait: counter got %0d want 100", counter); end
        n_cmp++; if (adcCs !== 1'b0) begin n_err++; $display("FAIL mid_active: adcCs got %b want 0", adcCs); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (adcCs !== 1'b1) begin n_err++; $display("FAIL mid_cs: got %b want 1", adcCs); end
        n_cmp++; if (adcSclk !== 1'b0) begin n_err++; $display("FAIL mid_sclk: got %b want 0", adcSclk); end
        n_cmp++; if (counter !== 10'd0) begin n_err++; $display("FAIL mid_counter: got %0d want 0", counter); end
        reset = 1'b1;
    endtask

    task automatic test_calibration;
        bit ok;
        for (int k = 1; k <= 64; k++) begin
            adc_val = (k <= 32) ? 10'h1F0 : 10'h210;
            wait_cnt(LAST, RL + 5, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL cal_wait%0d: counter got %0d want %0d", k, counter, LAST); end
            n_cmp++; if (sampleVoltage !== adc_val) begin n_err++; $display("FAIL cal_sample%0d: got %h want %h", k, sampleVoltage, adc_val); end
            if (k == 3) begin
                n_cmp++; if (calDone2 !== 1'b0) begin n_err++; $display("FAIL cal4_early: calDone got %b want 0", calDone2); end
            end
            if (k == 4) begin
                n_cmp++; if (offset2 !== 10'h1F0) begin n_err++; $display("FAIL cal4_offset: got %h want 1f0", offset2); end
                n_cmp++; if (calDone2 !== 1'b1) begin n_err++; $display("FAIL cal4_done: got %b want 1", calDone2); end
            end
            if (k == 63) begin
                n_cmp++; if (calDone !== 1'b0) begin n_err++; $display("FAIL cal_early: calDone got %b want 0", calDone); end
            end
            if (k == 64) begin
                n_cmp++; if (offset !== 10'h200) begin n_err++; $display("FAIL cal_offset: got %h want 200", offset); end
                n_cmp++; if (calDone !== 1'b1) begin n_err++; $display("FAIL cal_done: got %b want 1", calDone); end
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        adc_val = 10'h3FF;
        for (int r = 0; r < 3; r++) begin
            wait_cnt(PEN, RL + 5, ok);
            n_cmp++; if (!ok || sampleValid !== 1'b0) begin n_err++; $display("FAIL b2b_pre%0d: counter %0d valid %b want %0d/0", r, counter, sampleValid, PEN); end
            @(negedge clk);
            n_cmp++; if (counter !== LAST || sampleValid !== 1'b1) begin n_err++; $display("FAIL b2b_last%0d: counter %0d valid %b want %0d/1", r, counter, sampleValid, LAST); end
            n_cmp++; if (sampleVoltage !== 10'h3FF) begin n_err++; $display("FAIL b2b_sample%0d: got %h want 3ff", r, sampleVoltage); end
            n_cmp++; if (offset !== 10'h200 || calDone !== 1'b1) begin n_err++; $display("FAIL b2b_hold%0d: offset %h done %b want 200/1", r, offset, calDone); end
            @(negedge clk);
            n_cmp++; if (counter !== 10'd0 || sampleValid !== 1'b0) begin n_err++; $display("FAIL b2b_wrap%0d: counter %0d valid %b want 0/0", r, counter, sampleValid); end
        end
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL stray_valid: got %0d pulses off counter %0d want 0", stray, LAST); end
    endtask

`ifdef ADC_SAMPLER_RECAL_EN
    task automatic test_recal;
        bit ok;
        adc_val = 10'h180;
        recal = 1'b1;
        @(negedge clk);
        recal = 1'b0;
        n_cmp++; if (calDone !== 1'b0) begin n_err++; $display("FAIL recal_clear: calDone got %b want 0", calDone); end
        n_cmp++; if (offset !== 10'h200) begin n_err++; $display("FAIL recal_keep: offset got %h want 200", offset); end
        for (int k = 1; k <= 64; k++) begin
            wait_cnt(LAST, RL + 5, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL recal_wait%0d: counter got %0d want %0d", k, counter, LAST); end
            if (k == 4) begin
                n_cmp++; if (offset2 !== 10'h180 || calDone2 !== 1'b1) begin n_err++; $display("FAIL recal4: offset %h done %b want 180/1", offset2, calDone2); end
            end
            if (k == 63) begin
                n_cmp++; if (offset !== 10'h200 || calDone !== 1'b0) begin n_err++; $display("FAIL recal_early: offset %h done %b want 200/0", offset, calDone); end
            end
            if (k == 64) begin
                n_cmp++; if (offset !== 10'h180 || calDone !== 1'b1) begin n_err++; $display("FAIL recal_final: offset %h done %b want 180/1", offset, calDone); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_conversion();
        test_reset_mid();
        test_calibration();
        test_back_to_back();
`ifdef ADC_SAMPLER_RECAL_EN
        test_recal();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
